flt_cmd_proc: RTL
=================

# flt_cmd_proc

Command processor for the quadcopter link, downstream of `UART_comm` on the airframe side. It consumes each 24-bit command (`cmd` byte plus `data` word) that `UART_comm` has assembled. It applies the command to the flight setpoint registers or the calibration/motor controls, and returns a one-byte response through `UART_comm`'s `send_resp`/`resp_sent` handshake. A link watchdog levels the craft when commands stop arriving.

## Interface
- `WD_BITS`, 26: watchdog counter width; expiry after 2^WD_BITS−1 idle cycles (~1.34 s at 50 MHz).
- `THR_MAX`, 9'h1FF: thrust saturation value.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_rdy`  in  1  level from `UART_comm`; `cmd`/`data` valid while high
- `cmd`  in  8  opcode
- `data`  in  16  operand
- `clr_cmd_rdy`  out  1  one-cycle pulse acknowledging consumption of the command
- `resp`  out  8  response byte; held stable from `send_resp` until the next command
- `send_resp`  out  1  one-cycle pulse requesting transmission of `resp`
- `resp_sent`  in  1  pulse from `UART_comm` when `resp` has gone out
- `strt_cal`  out  1  one-cycle pulse starting inertial calibration
- `cal_done`  in  1  pulse from inertial block when calibration finishes
- `d_ptch`, `d_roll`, `d_yaw`  out  16 each  signed setpoints
- `thrst`  out  9  unsigned thrust setpoint
- `motors_off`  out  1  forces ESC outputs to zero

## Operation
- Opcodes:
  - 0x02 SET_PTCH: `d_ptch`←`data`.
  - 0x03 SET_ROLL: `d_roll`←`data`.
  - 0x04 SET_YAW: `d_yaw`←`data`.
  - 0x05 SET_THRST: `thrst`←min(`data`, THR_MAX), unsigned compare on all 16 bits.
  - 0x06 CALIBRATE: pulse `strt_cal`, wait for `cal_done`, then clear `motors_off`.
  - 0x07 EMER_LAND: `d_ptch`, `d_roll`, `d_yaw` and `thrst` ← 0.
  - 0x08 MTRS_OFF: `motors_off`←1, `thrst`←0.
- Response: every recognised opcode returns ACK 0xA5. Any other opcode changes no register and returns NAK 0xEE.
- States and transitions:
  - IDLE→ACCEPT when `cmd_rdy`=1. In ACCEPT, `cmd`/`data` are latched internally.
  - ACCEPT→EXEC.
  - EXEC→CAL_WAIT for CALIBRATE; otherwise EXEC→RESP.
  - CAL_WAIT→RESP on `cal_done`.
  - RESP→WAIT_SENT.
  - WAIT_SENT→IDLE on `resp_sent`.
- `cmd_rdy` is ignored outside IDLE. `UART_comm` holds it, so no command is lost.
- `cal_done` is ignored outside CAL_WAIT.
- Watchdog:
  - Counter clears on each ACCEPT and otherwise increments, saturating at all-ones.
  - On the cycle it reaches all-ones, `d_ptch`, `d_roll` and `d_yaw` are forced to 0. `thrst` and `motors_off` are untouched.
  - Expiry sends no response.
  - If an EXEC write coincides with expiry, the write wins. ACCEPT already restarted the counter, so this case is consistent.

## Timing
- Reset values:
  - state IDLE; `resp`=0x00.
  - `send_resp`, `clr_cmd_rdy` and `strt_cal` =0.
  - All setpoints 0.
  - `motors_off`=1.
  - Watchdog counter=0.
- `cmd_rdy` sampled high in IDLE at cycle N:
  - N+1: `clr_cmd_rdy`=1 (ACCEPT).
  - N+2: EXEC; setpoint updates take effect at the end of N+2 and are visible from N+3.
  - N+3: `send_resp`=1 with `resp` valid (RESP).
- CALIBRATE:
  - `strt_cal`=1 in cycle N+3, the first cycle of CAL_WAIT.
  - `cal_done` at cycle M gives `motors_off`=0 from M+1 and `send_resp`=1 at M+1.
- `resp_sent` in the same cycle as `send_resp` is not accepted. It is recognised only in WAIT_SENT.
- `rst` mid-operation:
  - Returns all outputs to reset values next cycle and abandons any pending response.
  - No `clr_cmd_rdy` is issued if reset lands in ACCEPT.
- All outputs are registered; no combinational input→output paths.

## Structure
- `flt_cmd_pkg` contains:
  - the opcode enum;
  - `RESP_ACK`=8'hA5 and `RESP_NAK`=8'hEE;
  - the state enum `{IDLE, ACCEPT, EXEC, CAL_WAIT, RESP, WAIT_SENT}`.
- Sub-module `flt_link_wdog` (parameter WD_BITS; ports `clk`, `rst`, `kick`, `expired`) holds the saturating counter.
- Everything else lives in `flt_cmd_proc`.

## Test plan
- SET_PTCH with data 0xFF38: `clr_cmd_rdy` at N+1, `d_ptch`=0xFF38 from N+3, `send_resp`=1 with `resp`=0xA5 at N+3. Other setpoints stay unchanged.
- SET_THRST data 0x0300: `thrst`=0x1FF. Then data 0x0123: `thrst`=0x123. Both return ACK.
- CALIBRATE with `cal_done` 40 cycles after `strt_cal`: exactly one `strt_cal` pulse, no `send_resp` before `cal_done`, `motors_off` 1→0 and ACK one cycle after `cal_done`. A spurious `cal_done` in IDLE has no effect.
- Opcode 0x5A: `resp`=0xEE and all setpoints unchanged. Then MTRS_OFF after thrust 0x080: `thrst`=0 and `motors_off`=1.
- WD_BITS=6:
  - Set pitch, roll and yaw non-zero, then idle 63 cycles. All three read 0 with no `send_resp`.
  - Repeat with a command every 50 cycles. There is no expiry.
- `rst` asserted in CAL_WAIT and in WAIT_SENT: next cycle state IDLE, `motors_off`=1, setpoints 0. Next command is processed normally.

Source files
------------

// File: rtl/flt_cmd_pkg.sv
// Shared definitions for the quadcopter link command processor.
//   opcode_e   : command opcodes understood by flt_cmd_proc
//   RESP_ACK/NAK : response bytes returned to UART_comm
//   state_e    : command sequencer states
//   op_known() : true for any opcode that is executed and ACKed
package flt_cmd_pkg;

  typedef enum logic [7:0] {
    OP_SET_PTCH  = 8'h02,
    OP_SET_ROLL  = 8'h03,
    OP_SET_YAW   = 8'h04,
    OP_SET_THRST = 8'h05,
    OP_CALIBRATE = 8'h06,
    OP_EMER_LAND = 8'h07,
    OP_MTRS_OFF  = 8'h08
  } opcode_e;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    EXEC,
    CAL_WAIT,
    RESP,
    WAIT_SENT
  } state_e;

  // Recognised opcodes form one contiguous range.
  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_SET_PTCH) && (op <= OP_MTRS_OFF);
  endfunction

endpackage

// File: rtl/flt_link_wdog.sv
// Link watchdog: saturating idle counter, cleared by kick.
//   clk     : system clock
//   rst     : synchronous active-high reset (counter to 0)
//   kick    : clears the counter this cycle
//   expired : high while the counter sits at all-ones
module flt_link_wdog #(
  parameter int WD_BITS = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  logic [WD_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + {{(WD_BITS-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '1);

endmodule

// File: rtl/flt_cmd_proc.sv
// Command processor for the quadcopter link (airframe side of UART_comm).
// Executes 24-bit commands against the flight setpoints and calibration/
// motor controls, returns a one-byte ACK/NAK, and levels the craft when
// the link goes quiet.
//   clk, rst                  : clock, synchronous active-high reset
//   cmd_rdy, cmd, data        : command from UART_comm (held until consumed)
//   clr_cmd_rdy               : one-cycle consume acknowledge
//   resp, send_resp, resp_sent: response byte and transmit handshake
//   strt_cal, cal_done        : inertial calibration handshake
//   d_ptch, d_roll, d_yaw     : signed attitude setpoints
//   thrst                     : unsigned thrust setpoint
//   motors_off                : forces ESC outputs to zero
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for cmd_rdy
// ACCEPT    | clr_cmd_rdy high, cmd/data latched, watchdog kicked
// EXEC      | opcode applied, response byte chosen
// CAL_WAIT  | strt_cal issued, waiting for cal_done
// RESP      | send_resp high
// WAIT_SENT | waiting for resp_sent from UART_comm
module flt_cmd_proc
  import flt_cmd_pkg::*;
#(
  parameter int         WD_BITS = 26,
  parameter logic [8:0] THR_MAX = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        motors_off
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  resp_q, resp_d;
  logic        send_resp_q, send_resp_d;
  logic        clr_q, clr_d;
  logic        strt_cal_q, strt_cal_d;
  logic [15:0] ptch_q, ptch_d;
  logic [15:0] roll_q, roll_d;
  logic [15:0] yaw_q, yaw_d;
  logic [8:0]  thrst_q, thrst_d;
  logic        motors_off_q, motors_off_d;
  logic        wd_expired;

  flt_link_wdog #(.WD_BITS(WD_BITS)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (state_q == ACCEPT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    resp_d       = resp_q;
    send_resp_d  = 1'b0;
    clr_d        = 1'b0;
    strt_cal_d   = 1'b0;
    ptch_d       = ptch_q;
    roll_d       = roll_q;
    yaw_d        = yaw_q;
    thrst_d      = thrst_q;
    motors_off_d = motors_off_q;

    // Leveling comes first so a coincident EXEC write overrides it.
    if (wd_expired) begin
      ptch_d = '0;
      roll_d = '0;
      yaw_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          state_d = ACCEPT;
          clr_d   = 1'b1;
        end
      end
      ACCEPT: begin
        cmd_d   = cmd;
        data_d  = data;
        state_d = EXEC;
      end
      EXEC: begin
        state_d     = RESP;
        send_resp_d = 1'b1;
        resp_d      = op_known(cmd_q) ? RESP_ACK : RESP_NAK;
        case (cmd_q)
          OP_SET_PTCH:  ptch_d = data_q;
          OP_SET_ROLL:  roll_d = data_q;
          OP_SET_YAW:   yaw_d  = data_q;
          OP_SET_THRST: thrst_d = (data_q > {7'd0, THR_MAX}) ? THR_MAX : data_q[8:0];
          OP_CALIBRATE: begin
            state_d     = CAL_WAIT;
            send_resp_d = 1'b0;
            strt_cal_d  = 1'b1;
          end
          OP_EMER_LAND: begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
          end
          OP_MTRS_OFF: begin
            motors_off_d = 1'b1;
            thrst_d      = '0;
          end
          default: ;
        endcase
      end
      CAL_WAIT: begin
        if (cal_done) begin
          motors_off_d = 1'b0;
          send_resp_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: state_d = WAIT_SENT;
      WAIT_SENT: begin
        if (resp_sent) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      data_q       <= '0;
      resp_q       <= '0;
      send_resp_q  <= 1'b0;
      clr_q        <= 1'b0;
      strt_cal_q   <= 1'b0;
      ptch_q       <= '0;
      roll_q       <= '0;
      yaw_q        <= '0;
      thrst_q      <= '0;
      motors_off_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      resp_q       <= resp_d;
      send_resp_q  <= send_resp_d;
      clr_q        <= clr_d;
      strt_cal_q   <= strt_cal_d;
      ptch_q       <= ptch_d;
      roll_q       <= roll_d;
      yaw_q        <= yaw_d;
      thrst_q      <= thrst_d;
      motors_off_q <= motors_off_d;
    end
  end

  assign clr_cmd_rdy = clr_q;
  assign resp        = resp_q;
  assign send_resp   = send_resp_q;
  assign strt_cal    = strt_cal_q;
  assign d_ptch      = ptch_q;
  assign d_roll      = roll_q;
  assign d_yaw       = yaw_q;
  assign thrst       = thrst_q;
  assign motors_off  = motors_off_q;

endmodule
